// File: rtl/user_wb_mailbox_pkg.sv
// Shared register map, STATUS/CTRL bit positions and STATUS packing helper
// for the Wishbone mailbox FIFO.
package user_wb_mailbox_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_idx_e;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVERFLOW  = 2;
    localparam int unsigned ST_UNDERFLOW = 3;
    localparam int unsigned ST_COUNT_LSB = 8;

    localparam int unsigned CTRL_FLUSH  = 0;
    localparam int unsigned CTRL_CLEAR  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    function automatic logic [31:0] pack_status(input logic       empty,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic       unf,
                                                input logic [7:0] count);
        logic [31:0] s;
        s                            = '0;
        s[ST_EMPTY]                  = empty;
        s[ST_FULL]                   = full;
        s[ST_OVERFLOW]               = ovf;
        s[ST_UNDERFLOW]              = unf;
        s[ST_COUNT_LSB +: 8]         = count;
        return s;
    endfunction

endpackage

// File: rtl/user_wb_mailbox_fifo_sync.sv
// Synchronous FIFO storage for the mailbox: memory, wrapping pointers and an
// occupancy count one bit wider than the pointers.
module mailbox_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            wr_data_i,
    output logic [DW-1:0]            rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    // Next pointer/count values; flush wins over any transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/user_wb_mailbox_fifo.sv
// Wishbone slave mailbox: DATA push/pop, STATUS, CTRL and THRESH registers,
// single-cycle registered ack and a registered level interrupt.
module user_wb_mailbox_fifo
    import user_wb_mailbox_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [DW-1:0] wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [DW-1:0] wbs_dat_o,
    output logic          irq_o
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          ack_q, ack_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          irq_q, irq_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          irq_en_q, irq_en_d;
    logic [7:0]    thresh_q, thresh_d;

    logic          req;
    logic          push, pop, flush;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count, count_nxt;
    reg_idx_e      idx;

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:1]};

    assign req = wbs_cyc_i && wbs_stb_i && !ack_q;
    assign idx = reg_idx_e'(wbs_adr_i[3:2]);

    mailbox_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .flush_i   (flush),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (wbs_dat_i),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Register decode: side effects and read data for the accepted request.
    always_comb begin
        ack_d    = req;
        dat_d    = '0;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (req) begin
            unique case (idx)
                REG_DATA: begin
                    if (wbs_we_i) begin
                        if (fifo_full) ovf_d = 1'b1;
                        else           push  = 1'b1;
                    end else begin
                        if (fifo_empty) unf_d = 1'b1;
                        else begin
                            pop   = 1'b1;
                            dat_d = fifo_rd_data;
                        end
                    end
                end
                REG_STATUS: begin
                    if (!wbs_we_i)
                        dat_d = pack_status(fifo_empty, fifo_full, ovf_q, unf_q, 8'(fifo_count));
                end
                REG_CTRL: begin
                    if (wbs_we_i) begin
                        if (wbs_sel_i[0]) begin
                            flush    = wbs_dat_i[CTRL_FLUSH];
                            irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
                            if (wbs_dat_i[CTRL_CLEAR]) begin
                                ovf_d = 1'b0;
                                unf_d = 1'b0;
                            end
                        end
                    end else begin
                        dat_d[CTRL_IRQ_EN] = irq_en_q;
                    end
                end
                REG_THRESH: begin
                    if (wbs_we_i) begin
                        if (wbs_sel_i[0]) thresh_d = wbs_dat_i[7:0];
                    end else begin
                        dat_d[7:0] = thresh_q;
                    end
                end
            endcase
        end
    end

    // Occupancy after this edge, so irq tracks the count change on the same edge.
    always_comb begin
        count_nxt = fifo_count;
        if (flush)     count_nxt = '0;
        else if (push) count_nxt = fifo_count + CW'(1);
        else if (pop)  count_nxt = fifo_count - CW'(1);
        irq_d = irq_en_d && (8'(count_nxt) >= thresh_d) && (thresh_d != 8'd0);
    end

    // Bus-facing and CSR registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= '0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_user_wb_mailbox_fifo.sv
// Self-checking bench for the Wishbone mailbox FIFO against a queue-based model.
module tb_user_wb_mailbox_fifo;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        irq;

    always #5 clk = ~clk;

    user_wb_mailbox_fifo #(
        .DEPTH (DEPTH),
        .DW    (32)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .irq_o     (irq)
    );

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Reference model: mailbox contents and CSR state.
    logic [31:0] mq[$];
    logic        m_ovf, m_unf, m_irq_en;
    logic [7:0]  m_thresh;

    function automatic logic m_irq();
        return m_irq_en && (mq.size() >= int'(m_thresh)) && (m_thresh != 8'd0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_irq_en = 1'b0; m_thresh = 8'd0;
    endtask

    task automatic model_access(input logic w, input logic [1:0] idx, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] exp);
        exp = 32'h0;
        case (idx)
            2'd0: begin
                if (w) begin
                    if (mq.size() < DEPTH) mq.push_back(d);
                    else m_ovf = 1'b1;
                end else begin
                    if (mq.size() > 0) exp = mq.pop_front();
                    else m_unf = 1'b1;
                end
            end
            2'd1: if (!w) exp = (mq.size() << 8) | (32'(m_unf) << 3) | (32'(m_ovf) << 2)
                                | (32'(mq.size() == DEPTH) << 1) | 32'(mq.size() == 0);
            2'd2: begin
                if (w) begin
                    if (s[0]) begin
                        if (d[0]) mq.delete();
                        if (d[1]) begin m_ovf = 1'b0; m_unf = 1'b0; end
                        m_irq_en = d[2];
                    end
                end else exp = 32'(m_irq_en) << 2;
            end
            default: begin
                if (w) begin
                    if (s[0]) m_thresh = d[7:0];
                end else exp = {24'h0, m_thresh};
            end
        endcase
    endtask

    // Single Wishbone transfer with bounded ack wait and one-cycle ack width check.
    task automatic bus(input logic w, input logic [1:0] idx, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r, output logic irq_at);
        int unsigned n;
        logic [31:0] ra;
        ra = $urandom();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; wdat = d;
        adr = {ra[31:4], idx, ra[1:0]};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        n_checks++;
        if (ack !== 1'b1 || n != 1) begin
            n_fails++;
            $display("FAIL ack_latency: ack=%b after %0d cycles, required ack=1 after 1", ack, n);
        end
        r = rdat;
        irq_at = irq;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || rdat !== 32'h0) begin
            n_fails++;
            $display("FAIL ack_width: ack=%b dat=%h, required ack=0 dat=00000000", ack, rdat);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] r, e;
        logic ia;
        do_reset();
        n_checks++;
        if (ack !== 1'b0 || rdat !== 32'h0 || irq !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_outputs: ack=%b dat=%h irq=%b, required 0/00000000/0", ack, rdat, irq);
        end
        bus(1'b0, 2'd1, 32'h0, 4'hF, r, ia);
        model_access(1'b0, 2'd1, 32'h0, 4'hF, e);
        n_checks++;
        if (r !== e || r !== 32'h0000_0001) begin
            n_fails++;
            $display("FAIL reset_status: got %h, required %h", r, e);
        end
        bus(1'b0, 2'd2, 32'h0, 4'hF, r, ia);
        model_access(1'b0, 2'd2, 32'h0, 4'hF, e);
        n_checks++;
        if (r !== e || ia !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_ctrl: got %h irq=%b, required %h irq=0", r, ia, e);
        end
    endtask

    task automatic test_fifo_order();
        logic [31:0] r, e;
        logic ia;
        for (int i = 1; i <= 3; i++) begin
            bus(1'b1, 2'd0, 32'hA5A5_0000 + 32'(i), 4'($urandom_range(0, 15)), r, ia);
            model_access(1'b1, 2'd0, 32'hA5A5_0000 + 32'(i), 4'hF, e);
        end
        for (int i = 1; i <= 3; i++) begin
            bus(1'b0, 2'd0, 32'h0, 4'hF, r, ia);
            model_access(1'b0, 2'd0, 32'h0, 4'hF, e);
            n_checks++;
            if (r !== e) begin
                n_fails++;
                $display("FAIL order_pop%0d: got %h, required %h", i, r, e);
            end
        end
        bus(1'b0, 2'd1, 32'h0, 4'hF, r, ia);
        model_access(1'b0, 2'd1, 32'h0, 4'hF, e);
        n_checks++;
        if (r !== e) begin
            n_fails++;
            $display("FAIL order_status: got %h, required %h", r, e);
        end
    endtask

    task automatic test_overflow_wrap();
        logic [31:0] r, e, v;
        logic ia;
        for (int i = 1; i <= 17; i++) begin
            bus(1'b1, 2'd0, 32'(i), 4'hF, r, ia);
            model_access(1'b1, 2'd0, 32'(i), 4'hF, e);
        end
        bus(1'b0, 2'd1, 32'h0, 4'hF, r, ia);
        model_access(1'b0, 2'd1, 32'h0, 4'hF, e);
        n_checks++;
        if (r !== e) begin
            n_fails++;
            $display("FAIL full_status: got %h, required %h", r, e);
        end
        for (int i = 1; i <= 16; i++) begin
            bus(1'b0, 2'd0, 32'h0, 4'hF, r, ia);
            model_access(1'b0, 2'd0, 32'h0, 4'hF, e);
            n_checks++;
            if (r !== e) begin
                n_fails++;
                $display("FAIL full_pop%0d: got %h, required %h", i, r, e);
            end
        end
        // Second fill with offset pointers so both wrap mid-sequence.
        for (int ph = 0; ph < 4; ph++) begin
            int unsigned cnt;
            logic wr;
            wr  = (ph % 2 == 0);
            cnt = (ph == 0) ? 10 : (ph == 1) ? 7 : (ph == 2) ? 13 : 16;
            for (int unsigned i = 0; i < cnt; i++) begin
                v = $urandom();
                bus(wr, 2'd0, v, 4'hF, r, ia);
                model_access(wr, 2'd0, v, 4'hF, e);
                if (!wr) begin
                    n_checks++;
                    if (r !== e) begin
                        n_fails++;
                        $display("FAIL wrap_pop: got %h, required %h", r, e);
                    end
                end
            end
        end
    endtask

    task automatic test_underflow();
        logic [31:0] r, e;
        logic ia;
        bus(1'b0, 2'd0, 32'h0, 4'hF, r, ia);
        model_access(1'b0, 2'd0, 32'h0, 4'hF, e);
        n_checks++;
        if (r !== e) begin
            n_fails++;
            $display("FAIL underflow_data: got %h, required %h", r, e);
        end
        bus(1'b0, 2'd1, 32'h0, 4'hF, r, ia);
        model_access(1'b0, 2'd1, 32'h0, 4'hF, e);
        n_checks++;
        if (r !== e) begin
            n_fails++;
            $display("FAIL underflow_status: got %h, required %h", r, e);
        end
        bus(1'b1, 2'd2, 32'h2, 4'h1, r, ia);
        model_access(1'b1, 2'd2, 32'h2, 4'h1, e);
        bus(1'b0, 2'd1, 32'h0, 4'hF, r, ia);
        model_access(1'b0, 2'd1, 32'h0, 4'hF, e);
        n_checks++;
        if (r !== e) begin
            n_fails++;
            $display("FAIL clear_status: got %h, required %h", r, e);
        end
    endtask

    task automatic test_irq();
        logic [31:0] r, e, v;
        logic ia;
        bus(1'b1, 2'd3, 32'h4, 4'h1, r, ia);
        model_access(1'b1, 2'd3, 32'h4, 4'h1, e);
        bus(1'b1, 2'd2, 32'h4, 4'h1, r, ia);
        model_access(1'b1, 2'd2, 32'h4, 4'h1, e);
        for (int i = 1; i <= 4; i++) begin
            v = $urandom();
            bus(1'b1, 2'd0, v, 4'hF, r, ia);
            model_access(1'b1, 2'd0, v, 4'hF, e);
            n_checks++;
            if (ia !== m_irq()) begin
                n_fails++;
                $display("FAIL irq_push%0d: got %b, required %b", i, ia, m_irq());
            end
        end
        bus(1'b0, 2'd0, 32'h0, 4'hF, r, ia);
        model_access(1'b0, 2'd0, 32'h0, 4'hF, e);
        n_checks++;
        if (ia !== m_irq() || r !== e) begin
            n_fails++;
            $display("FAIL irq_pop: got irq=%b dat=%h, required irq=%b dat=%h", ia, r, m_irq(), e);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r, e, v;
        logic ia;
        bus(1'b1, 2'd2, 32'h5, 4'h1, r, ia);
        model_access(1'b1, 2'd2, 32'h5, 4'h1, e);
        bus(1'b0, 2'd0, 32'h0, 4'hF, r, ia);
        model_access(1'b0, 2'd0, 32'h0, 4'hF, e);
        bus(1'b1, 2'd3, 32'h4, 4'h1, r, ia);
        model_access(1'b1, 2'd3, 32'h4, 4'h1, e);
        for (int i = 0; i < 5; i++) begin
            v = $urandom();
            bus(1'b1, 2'd0, v, 4'hF, r, ia);
            model_access(1'b1, 2'd0, v, 4'hF, e);
        end
        n_checks++;
        if (irq !== m_irq()) begin
            n_fails++;
            $display("FAIL flush_pre_irq: got %b, required %b", irq, m_irq());
        end
        bus(1'b1, 2'd2, 32'h5, 4'h1, r, ia);
        model_access(1'b1, 2'd2, 32'h5, 4'h1, e);
        n_checks++;
        if (ia !== m_irq()) begin
            n_fails++;
            $display("FAIL flush_irq: got %b, required %b", ia, m_irq());
        end
        bus(1'b0, 2'd1, 32'h0, 4'hF, r, ia);
        model_access(1'b0, 2'd1, 32'h0, 4'hF, e);
        n_checks++;
        if (r !== e) begin
            n_fails++;
            $display("FAIL flush_status: got %h, required %h", r, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        logic [31:0] r, e;
        logic ia;
        int unsigned n;
        bus(1'b1, 2'd2, 32'h3, 4'h1, r, ia);
        model_access(1'b1, 2'd2, 32'h3, 4'h1, e);
        for (int i = 0; i < 4; i++) vals[i] = $urandom();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h0; wdat = vals[0];
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ack && n < 8);
            n_checks++;
            if (ack !== 1'b1 || n != ((i == 0) ? 1 : 2)) begin
                n_fails++;
                $display("FAIL b2b_spacing%0d: ack=%b after %0d cycles, required %0d", i, ack, n, (i == 0) ? 1 : 2);
            end
            model_access(1'b1, 2'd0, vals[i], 4'hF, e);
            if (i < 3) wdat = vals[i+1];
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus(1'b0, 2'd0, 32'h0, 4'hF, r, ia);
            model_access(1'b0, 2'd0, 32'h0, 4'hF, e);
            n_checks++;
            if (r !== e) begin
                n_fails++;
                $display("FAIL b2b_pop%0d: got %h, required %h", i, r, e);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r, e, d;
        logic [3:0] s;
        logic [1:0] idx;
        logic w, ia;
        int unsigned op;
        for (int k = 0; k < 150; k++) begin
            op = $urandom_range(0, 9);
            s  = 4'($urandom_range(0, 15));
            d  = $urandom();
            if (op <= 3)      begin idx = 2'd0; w = 1'b1; end
            else if (op <= 6) begin idx = 2'd0; w = 1'b0; end
            else if (op == 7) begin idx = 2'd1; w = 1'($urandom_range(0, 1)); end
            else if (op == 8) begin
                idx = 2'd2; w = 1'($urandom_range(0, 1));
                d[0] = ($urandom_range(0, 5) == 0);
            end else begin
                idx = 2'd3; w = 1'($urandom_range(0, 1));
                d[7:0] = 8'($urandom_range(0, 17));
            end
            bus(w, idx, d, s, r, ia);
            model_access(w, idx, d, s, e);
            n_checks++;
            if (r !== e || ia !== m_irq()) begin
                n_fails++;
                $display("FAIL random%0d: we=%b reg=%0d got dat=%h irq=%b, required dat=%h irq=%b",
                         k, w, idx, r, ia, e, m_irq());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, e, v;
        logic ia;
        bus(1'b1, 2'd3, 32'h2, 4'h1, r, ia);
        model_access(1'b1, 2'd3, 32'h2, 4'h1, e);
        bus(1'b1, 2'd2, 32'h4, 4'h1, r, ia);
        model_access(1'b1, 2'd2, 32'h4, 4'h1, e);
        for (int i = 0; i < 3; i++) begin
            v = $urandom();
            bus(1'b1, 2'd0, v, 4'hF, r, ia);
            model_access(1'b1, 2'd0, v, 4'hF, e);
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b1) begin
            n_fails++;
            $display("FAIL midrst_ack_before: got %b, required 1", ack);
        end
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || rdat !== 32'h0 || irq !== 1'b0) begin
            n_fails++;
            $display("FAIL midrst_outputs: ack=%b dat=%h irq=%b, required 0/00000000/0", ack, rdat, irq);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            bus(1'b0, 2'(i), 32'h0, 4'hF, r, ia);
            model_access(1'b0, 2'(i), 32'h0, 4'hF, e);
            n_checks++;
            if (r !== e || ia !== 1'b0) begin
                n_fails++;
                $display("FAIL midrst_reg%0d: got %h irq=%b, required %h irq=0", i, r, ia, e);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fifo_order();
        test_overflow_wrap();
        test_underflow();
        test_irq();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
